// File: rtl/pspin_pkt_ring_writer.sv
// pspin_pkt_ring_writer
//
// Ingress stage behind the PsPIN packet match engine. Each matched AXI-Stream
// frame is copied into one fixed-size slot of a circular packet buffer in L2
// memory. After the frame's last beat, a descriptor (slot address, byte
// length, truncation flag) goes to the handler scheduler. Slots come back
// through in-order release pulses. While every slot is occupied, incoming
// frames are consumed and counted as drops.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   s_axis_*             matched-frame stream in (tkeep contiguous from bit 0)
//   mem_wr_*             L2 write port, one beat per request
//   m_desc_*             per-frame descriptor out (valid/ready)
//   slot_release         one-cycle pulse, the oldest occupied slot is free again
//   stat_pkt_count       descriptors issued (wraps at 2^32)
//   stat_drop_count      frames dropped for lack of a slot (wraps at 2^32)

module pspin_pkt_ring_writer #(
  parameter int                    AXIS_IF_DATA_WIDTH = 512,
  parameter int                    AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
  parameter int                    ADDR_WIDTH         = 32,
  parameter int                    LEN_WIDTH          = 16,
  parameter logic [ADDR_WIDTH-1:0] BUF_BASE           = 32'h1000_0000,
  parameter int                    BUF_SLOTS          = 16,
  parameter int                    SLOT_SIZE          = 2048
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [AXIS_IF_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
  output logic [AXIS_IF_DATA_WIDTH-1:0] mem_wr_data,
  output logic [AXIS_IF_KEEP_WIDTH-1:0] mem_wr_strb,
  output logic                          mem_wr_valid,
  input  logic                          mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]         m_desc_addr,
  output logic [LEN_WIDTH-1:0]          m_desc_len,
  output logic                          m_desc_trunc,
  output logic                          m_desc_valid,
  input  logic                          m_desc_ready,
  input  logic                          slot_release,
  output logic [31:0]                   stat_pkt_count,
  output logic [31:0]                   stat_drop_count
);

  localparam int SLOT_W     = $clog2(BUF_SLOTS);
  localparam int SLOT_SHIFT = $clog2(SLOT_SIZE);
  // The offset has to reach SLOT_SIZE itself, since that value marks a full slot.
  localparam int OFF_W      = SLOT_SHIFT + 1;
  localparam int OCC_W      = $clog2(BUF_SLOTS + 1);
  localparam int KCNT_W     = $clog2(AXIS_IF_KEEP_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2,
    DESC  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] head_q, head_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic              trunc_q, trunc_d;
  logic [31:0]       pktCnt_q, pktCnt_d;
  logic [31:0]       dropCnt_q, dropCnt_d;

  logic [KCNT_W-1:0]     keepCnt;
  logic [ADDR_WIDTH-1:0] slotBase;
  logic                  slotFull;
  logic                  axisReady;
  logic                  memValid;
  logic                  descValid;
  logic                  descAccept;
  logic                  relAccept;

  // Count the valid bytes of the current beat. tkeep is contiguous, so this
  // count is also the beat's byte length.
  always_comb begin
    keepCnt = '0;
    for (int i = 0; i < AXIS_IF_KEEP_WIDTH; i++) begin
      keepCnt = keepCnt + KCNT_W'(s_axis_tkeep[i]);
    end
  end

  assign slotBase = BUF_BASE + (ADDR_WIDTH'(head_q) << SLOT_SHIFT);
  assign slotFull = (off_q == OFF_W'(SLOT_SIZE));

  // FSM next-state and handshake logic. Beats pass straight through to the
  // memory port with no buffering, so a memory stall back-pressures the stream.
  // Once the slot is full, the remaining beats are accepted and discarded so
  // that upstream can finish the frame.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    off_d      = off_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    pktCnt_d   = pktCnt_q;
    dropCnt_d  = dropCnt_q;
    axisReady  = 1'b0;
    memValid   = 1'b0;
    descValid  = 1'b0;
    descAccept = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          if (occ_q == OCC_W'(BUF_SLOTS)) begin
            state_d = DROP;
          end else begin
            state_d = WRITE;
            off_d   = '0;
            len_d   = '0;
            trunc_d = 1'b0;
          end
        end
      end

      WRITE: begin
        if (!slotFull) begin
          memValid  = s_axis_tvalid;
          axisReady = mem_wr_ready;
        end else begin
          axisReady = 1'b1;
        end
        if (s_axis_tvalid && axisReady) begin
          if (!slotFull) begin
            off_d = off_q + OFF_W'(AXIS_IF_KEEP_WIDTH);
            len_d = len_q + LEN_WIDTH'(keepCnt);
          end else begin
            trunc_d = 1'b1;
          end
          if (s_axis_tlast) begin
            state_d = DESC;
          end
        end
      end

      DROP: begin
        axisReady = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          dropCnt_d = dropCnt_q + 32'd1;
          state_d   = IDLE;
        end
      end

      DESC: begin
        descValid = 1'b1;
        if (m_desc_ready) begin
          descAccept = 1'b1;
          head_d     = head_q + SLOT_W'(1);
          pktCnt_d   = pktCnt_q + 32'd1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Occupancy tracking. A release at occupancy zero has nothing to free. A
  // release that lands together with a descriptor handshake cancels it out.
  assign relAccept = slot_release && (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (descAccept && !relAccept) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!descAccept && relAccept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // State registers. A reset abandons any partially written slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      head_q    <= '0;
      occ_q     <= '0;
      off_q     <= '0;
      len_q     <= '0;
      trunc_q   <= 1'b0;
      pktCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      occ_q     <= occ_d;
      off_q     <= off_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      pktCnt_q  <= pktCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign s_axis_tready   = axisReady;
  assign mem_wr_valid    = memValid;
  assign mem_wr_addr     = slotBase + ADDR_WIDTH'(off_q);
  assign mem_wr_data     = s_axis_tdata;
  assign mem_wr_strb     = s_axis_tkeep;
  assign m_desc_valid    = descValid;
  assign m_desc_addr     = slotBase;
  assign m_desc_len      = len_q;
  assign m_desc_trunc    = trunc_q;
  assign stat_pkt_count  = pktCnt_q;
  assign stat_drop_count = dropCnt_q;

endmodule

// File: tb/tb_pspin_pkt_ring_writer.sv
// tb_pspin_pkt_ring_writer
//
// Random frames are driven into pspin_pkt_ring_writer. A small ring model
// (head, occupancy, counters) predicts every memory write, every descriptor,
// every drop and both statistics counters.

module tb_pspin_pkt_ring_writer;

  localparam int          SLOTS     = 16;
  localparam int          SLOT_SIZE = 2048;
  localparam int          KEEP      = 64;
  localparam logic [31:0] BASE      = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [511:0]  s_axis_tdata = '0;
  logic [63:0]   s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [31:0]   mem_wr_addr;
  logic [511:0]  mem_wr_data;
  logic [63:0]   mem_wr_strb;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b1;
  logic [31:0]   m_desc_addr;
  logic [15:0]   m_desc_len;
  logic          m_desc_trunc;
  logic          m_desc_valid;
  logic          m_desc_ready = 1'b0;
  logic          slot_release = 1'b0;
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_drop_count;

  // Ring model state
  int modelHead = 0;
  int modelOcc  = 0;
  int modelPkt  = 0;
  int modelDrop = 0;
  int expWrites = 0;
  int writeCount = 0;
  int memMode = 0;

  int checks = 0;
  int failures = 0;

  pspin_pkt_ring_writer dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_strb     (mem_wr_strb),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_ready    (mem_wr_ready),
    .m_desc_addr     (m_desc_addr),
    .m_desc_len      (m_desc_len),
    .m_desc_trunc    (m_desc_trunc),
    .m_desc_valid    (m_desc_valid),
    .m_desc_ready    (m_desc_ready),
    .slot_release    (slot_release),
    .stat_pkt_count  (stat_pkt_count),
    .stat_drop_count (stat_drop_count)
  );

  always #5 clk = ~clk;

  // Memory-side back-pressure: 0 = always ready, 1 = toggle, 2 = random
  always @(posedge clk) begin
    #1;
    case (memMode)
      0:       mem_wr_ready = 1'b1;
      1:       mem_wr_ready = ~mem_wr_ready;
      default: mem_wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Count every completed memory write so that lost or extra beats show up
  always @(negedge clk) begin
    if (rstn && mem_wr_valid && mem_wr_ready) begin
      writeCount = writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_tready"},   s_axis_tready, 1'b0);
    checkOutput({pfx, "_wrvalid"},  mem_wr_valid, 1'b0);
    checkOutput({pfx, "_dvalid"},   m_desc_valid, 1'b0);
    checkOutput({pfx, "_daddr"},    m_desc_addr, BASE);
    checkOutput({pfx, "_dlen"},     m_desc_len, 16'd0);
    checkOutput({pfx, "_dtrunc"},   m_desc_trunc, 1'b0);
    checkOutput({pfx, "_pkt"},      stat_pkt_count, 32'd0);
    checkOutput({pfx, "_drop"},     stat_drop_count, 32'd0);
  endtask

  task automatic resetModel();
    modelHead = 0;
    modelOcc  = 0;
    modelPkt  = 0;
    modelDrop = 0;
  endtask

  // One release pulse between frames. The caller sits just after a rising edge.
  task automatic pulseRelease();
    slot_release = 1'b1;
    @(posedge clk); #1;
    slot_release = 1'b0;
    if (modelOcc > 0) modelOcc = modelOcc - 1;
  endtask

  // Send one frame and check all of its effects. abortAt >= 0 asserts reset
  // in place of driving that beat.
  task automatic applyStimulus(input int nbeats, input int lastKeep, input int hold,
                               input bit relOnDesc, input int abortAt);
    bit          dropExp;
    bit          accepted;
    int          guard;
    logic [31:0] slotAddr;
    int          expLen;
    bit          expTrunc;
    logic [511:0] d;
    logic [63:0]  k;

    dropExp  = (modelOcc == SLOTS);
    slotAddr = BASE + 32'(modelHead * SLOT_SIZE);
    expTrunc = (nbeats * KEEP > SLOT_SIZE) && (nbeats > SLOT_SIZE / KEEP);
    expLen   = (nbeats > SLOT_SIZE / KEEP) ? SLOT_SIZE : (nbeats - 1) * KEEP + lastKeep;

    for (int b = 0; b < nbeats; b++) begin
      if (b == abortAt) begin
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        checkResetOutputs("midrst");
        return;
      end
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
      k = '0;
      if (b == nbeats - 1) begin
        for (int i = 0; i < lastKeep; i++) k[i] = 1'b1;
      end else begin
        k = '1;
      end
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tvalid = 1'b1;

      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 100) begin
        @(negedge clk);
        guard = guard + 1;
        if (b == 0 && guard == 1) begin
          checkOutput("idle_tready", s_axis_tready, 1'b0);
        end else if (s_axis_tready) begin
          accepted = 1'b1;
        end
        if (!accepted) begin
          @(posedge clk); #1;
        end
      end
      if (!accepted) begin
        checkOutput("beat_timeout", 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        return;
      end

      if (!dropExp && b < SLOT_SIZE / KEEP) begin
        checkOutput("wr_valid", mem_wr_valid, 1'b1);
        checkOutput("wr_addr",  mem_wr_addr, slotAddr + 32'(b * KEEP));
        checkOutput("wr_data",  mem_wr_data, d);
        checkOutput("wr_strb",  mem_wr_strb, k);
        expWrites = expWrites + 1;
      end else begin
        checkOutput("wr_suppressed", mem_wr_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    if (dropExp) begin
      modelDrop = modelDrop + 1;
      @(negedge clk);
      checkOutput("drop_no_desc", m_desc_valid, 1'b0);
      checkOutput("drop_stat", stat_drop_count, 32'(modelDrop));
      @(posedge clk); #1;
      return;
    end

    // Descriptor: valid from the first cycle and stable while it is held
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        m_desc_ready = 1'b1;
        slot_release = relOnDesc;
      end
      @(negedge clk);
      checkOutput((h == 0) ? "desc_latency" : "desc_hold", m_desc_valid, 1'b1);
      checkOutput("desc_addr",  m_desc_addr, slotAddr);
      checkOutput("desc_len",   m_desc_len, 16'(expLen));
      checkOutput("desc_trunc", m_desc_trunc, expTrunc);
      @(posedge clk); #1;
    end
    m_desc_ready = 1'b0;
    slot_release = 1'b0;

    modelHead = (modelHead + 1) % SLOTS;
    modelPkt  = modelPkt + 1;
    if (!(relOnDesc && modelOcc > 0)) modelOcc = modelOcc + 1;

    @(negedge clk);
    checkOutput("desc_done", m_desc_valid, 1'b0);
    checkOutput("pkt_stat", stat_pkt_count, 32'(modelPkt));
    @(posedge clk); #1;
  endtask

  initial begin
    int r;
    int nb;
    int nrel;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single 100-byte frame: 64 + 36 bytes
    applyStimulus(2, 36, 0, 1'b0, -1);
    pulseRelease();

    // Fill the ring completely, then one more frame is dropped
    for (int f = 0; f < SLOTS + 1; f++) applyStimulus(1, 64, 0, 1'b0, -1);
    checkOutput("fill_drop", stat_drop_count, 32'd1);

    // One release frees exactly one slot, the next frame reuses the wrapped head
    pulseRelease();
    applyStimulus(1, 8, 0, 1'b0, -1);
    applyStimulus(1, 8, 0, 1'b0, -1);

    // Drain everything, then send an oversized 40-beat frame
    for (int i = 0; i < SLOTS + 2; i++) pulseRelease();
    applyStimulus(40, 64, 0, 1'b0, -1);

    // Toggling memory ready, descriptor held for 5 cycles, release on handshake
    memMode = 1;
    applyStimulus(5, 17, 5, 1'b1, -1);
    applyStimulus(3, 64, 5, 1'b1, -1);

    // Random traffic
    for (int f = 0; f < 60; f++) begin
      memMode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      nb = (r == 0) ? $urandom_range(30, 40) : $urandom_range(1, 6);
      applyStimulus(nb, $urandom_range(1, 64), $urandom_range(0, 5),
                    ($urandom_range(0, 2) == 0), -1);
      r = $urandom_range(0, 9);
      nrel = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      for (int i = 0; i < nrel; i++) pulseRelease();
    end

    // Reset in the middle of a 4-beat frame, then the next frame uses slot 0
    memMode = 0;
    applyStimulus(4, 64, 0, 1'b0, 2);
    @(posedge clk); #1;
    checkResetOutputs("inrst");
    rstn = 1'b1;
    resetModel();
    @(posedge clk); #1;
    applyStimulus(1, 20, 0, 1'b0, -1);
    checkOutput("post_rst_slot0", m_desc_addr, BASE + 32'(SLOT_SIZE));

    // No write lost or duplicated over the whole run
    checkOutput("write_total", writeCount, expWrites);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
